// File: rtl/antares_muldiv_ctrl.sv
// HILO sequencer for the EX stage: issues multiply/divide operations, latches the pending
// result kind, commits results to HILO and raises the EX stall and watchdog abort.
module antares_muldiv_ctrl #(
  parameter int ENABLE_HW_MULT = 1,
  parameter int ENABLE_HW_DIV  = 1,
  parameter int WATCHDOG       = 64   // legal range 8..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ex_alu_operation,
  input  logic       ex_b_is_zero,
  input  logic       ex_stall,
  input  logic       ex_flush,
  input  logic       mult_ready,
  input  logic       div_stall,
  output logic       mult_enable_op,
  output logic       mult_signed_op,
  output logic       op_divs,
  output logic       op_divu,
  output logic       hilo_we,
  output logic [2:0] hilo_src,
  output logic       ex_request_stall,
  output logic       muldiv_busy,
  output logic       muldiv_timeout
);

  localparam logic [4:0] OP_DIV   = 5'd5,  OP_DIVU  = 5'd6,  OP_MFHI  = 5'd7,
                         OP_MFLO  = 5'd8,  OP_MTHI  = 5'd9,  OP_MTLO  = 5'd10,
                         OP_MULS  = 5'd12, OP_MULU  = 5'd13, OP_MADD  = 5'd14,
                         OP_MADDU = 5'd15, OP_MSUB  = 5'd16, OP_MSUBU = 5'd17;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_MUL_WAIT = 2'd1, ST_DIV_WAIT = 2'd2;

  localparam logic [2:0] SRC_HOLD = 3'd0, SRC_DIV  = 3'd1, SRC_MULT = 3'd2,
                         SRC_MADD = 3'd3, SRC_MSUB = 3'd4, SRC_MTHI = 3'd5,
                         SRC_MTLO = 3'd6;

  localparam logic [7:0] WD_LAST = 8'(WATCHDOG - 1);
  localparam bit         HW_MULT = (ENABLE_HW_MULT != 0);
  localparam bit         HW_DIV  = (ENABLE_HW_DIV != 0);

  logic [1:0] state_q, state_d;
  logic [2:0] pend_kind_q, pend_kind_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;

  logic       enable_ex;
  logic       is_mult_op, is_div_op, hilo_access;
  logic [2:0] mult_kind;

  assign enable_ex = ~(ex_stall | ex_flush);

  always_comb begin
    mult_kind = SRC_HOLD;
    unique case (ex_alu_operation)
      OP_MULS,  OP_MULU:  mult_kind = SRC_MULT;
      OP_MADD,  OP_MADDU: mult_kind = SRC_MADD;
      OP_MSUB,  OP_MSUBU: mult_kind = SRC_MSUB;
      default:            mult_kind = SRC_HOLD;
    endcase
  end

  // Disabled units turn their opcodes into plain no-ops, so they never count as HILO access.
  assign is_mult_op  = HW_MULT && (mult_kind != SRC_HOLD);
  assign is_div_op   = HW_DIV && (ex_alu_operation == OP_DIV || ex_alu_operation == OP_DIVU);
  assign hilo_access = is_mult_op || is_div_op ||
                       ex_alu_operation == OP_MTHI || ex_alu_operation == OP_MTLO ||
                       ex_alu_operation == OP_MFHI || ex_alu_operation == OP_MFLO;

  always_comb begin
    // NOTE: every output and next-state is given a default first so no path infers a latch.
    state_d        = state_q;
    pend_kind_d    = pend_kind_q;
    wd_cnt_d       = wd_cnt_q;
    mult_enable_op = 1'b0;
    mult_signed_op = 1'b0;
    op_divs        = 1'b0;
    op_divu        = 1'b0;
    hilo_we        = 1'b0;
    hilo_src       = SRC_HOLD;
    muldiv_timeout = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_ex) begin
          if (is_mult_op) begin
            mult_enable_op = 1'b1;
            mult_signed_op = (ex_alu_operation == OP_MULS) || (ex_alu_operation == OP_MADD) ||
                             (ex_alu_operation == OP_MSUB);
            pend_kind_d    = mult_kind;
            wd_cnt_d       = '0;
            state_d        = ST_MUL_WAIT;
          end else if (is_div_op && !ex_b_is_zero) begin
            op_divs     = (ex_alu_operation == OP_DIV);
            op_divu     = (ex_alu_operation == OP_DIVU);
            pend_kind_d = SRC_DIV;
            wd_cnt_d    = '0;
            state_d     = ST_DIV_WAIT;
          end else if (ex_alu_operation == OP_MTHI) begin
            hilo_we  = 1'b1;
            hilo_src = SRC_MTHI;
          end else if (ex_alu_operation == OP_MTLO) begin
            hilo_we  = 1'b1;
            hilo_src = SRC_MTLO;
          end
        end
      end

      ST_MUL_WAIT, ST_DIV_WAIT: begin
        // Completion beats the watchdog when both land in the same cycle.
        if ((state_q == ST_MUL_WAIT) ? mult_ready : !div_stall) begin
          hilo_we  = 1'b1;
          hilo_src = (state_q == ST_MUL_WAIT) ? pend_kind_q : SRC_DIV;
          wd_cnt_d = '0;
          state_d  = ST_IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          muldiv_timeout = 1'b1;
          wd_cnt_d       = '0;
          state_d        = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The strobes decode live inputs, so they are forced quiet while reset is held.
    if (rst) begin
      mult_enable_op = 1'b0;
      mult_signed_op = 1'b0;
      op_divs        = 1'b0;
      op_divu        = 1'b0;
      hilo_we        = 1'b0;
      hilo_src       = SRC_HOLD;
      muldiv_timeout = 1'b0;
    end
  end

  assign muldiv_busy      = (state_q != ST_IDLE);
  assign ex_request_stall = muldiv_busy && hilo_access;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_kind_q <= SRC_HOLD;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_kind_q <= pend_kind_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

endmodule
